// File: rtl/wb_mem_wt_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_wt_sequencer_if
// Description : Bundles the WB store-request handshake and the MEM chunk
//               write port seen by wb_mem_wt_sequencer.
//               slave  = the sequencer itself
//               master = the surrounding WB control logic and MEM model
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_mem_wt_sequencer_if;

  // WB -> sequencer store request
  logic        req_v;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  logic [31:0] req_pa1;
  logic [31:0] req_pa2;
  logic        req_stall;

  // Sequencer -> MEM chunk write port
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_data;
  logic        mem_rdy;
  logic        done;

  modport slave (
    input  req_v, req_addr, req_size, req_data, req_pa1, req_pa2, mem_rdy,
    output req_stall, mem_en, mem_addr, mem_be, mem_data, done
  );

  modport master (
    output req_v, req_addr, req_size, req_data, req_pa1, req_pa2, mem_rdy,
    input  req_stall, mem_en, mem_addr, mem_be, mem_data, done
  );

endinterface
`default_nettype wire

// File: rtl/wb_mem_wt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_wt_sequencer
// Description : Turns one write-back store into one or two MEM write chunks.
//               A store that runs past the end of its page is split: the
//               first chunk lands in the PA1 frame, the remainder at offset 0
//               of the PA2 frame. WB is stalled until every chunk is taken.
// Options     : WB_SEQ_BYPASS_EN - when defined, an unsplit request arriving
//               in IDLE is presented to MEM in the same cycle and completes
//               with zero latency if MEM is ready.
// Parameters  : PAGE_BITS - log2 of page size in bytes (must be >= 4).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_wt_sequencer #(
  parameter int PAGE_BITS = 12
) (
  input  wire logic             CLK,
  input  wire logic             CLR,
  wb_mem_wt_sequencer_if.slave  bus
);

  localparam logic [PAGE_BITS:0] c_PAGE_SIZE = {1'b1, {PAGE_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND0 = 2'd1,
    S_SEND1 = 2'd2
  } state_t;

  // Contiguous byte-enable mask of n bytes starting at lane 0 (n = 0..8).
  function automatic logic [7:0] f_be_mask(input logic [3:0] n);
    return 8'hFF >> (4'd8 - n);
  endfunction

  // --------------------------------------------------------------------------
  // Chunk geometry of the incoming request. Computed from the live request
  // so the registered path can capture ready-made chunk descriptors and the
  // bypass path can present chunk 0 directly.
  // --------------------------------------------------------------------------
  logic [PAGE_BITS-1:0] w_off;
  logic [3:0]           w_bytes;
  logic [PAGE_BITS:0]   w_end;
  logic [PAGE_BITS:0]   w_room;
  logic                 w_split;
  logic [3:0]           w_bytes0;
  logic [3:0]           w_bytes1;
  logic [31:0]          w_addr0;
  logic [31:0]          w_addr1;
  logic [7:0]           w_be0;
  logic [7:0]           w_be1;
  logic [63:0]          w_data1;

  // Split decision and per-chunk address/enable/data for the request inputs.
  always_comb begin
    w_off    = bus.req_addr[PAGE_BITS-1:0];
    w_bytes  = 4'd1 << bus.req_size;
    // One extra bit so an 8-byte store near the top of the page cannot wrap.
    w_end    = {1'b0, w_off} + {{(PAGE_BITS-3){1'b0}}, w_bytes};
    // Ending exactly on the last byte of the page is still a single chunk.
    w_split  = (w_end > c_PAGE_SIZE);
    w_room   = c_PAGE_SIZE - {1'b0, w_off};
    // When split, the room left in the page is 1..7 bytes and fits in 4 bits.
    w_bytes0 = w_split ? w_room[3:0] : w_bytes;
    w_bytes1 = w_bytes - w_bytes0;
    // The offset is placed verbatim; the frame bits come only from PA1/PA2.
    w_addr0  = {bus.req_pa1[31:PAGE_BITS], w_off};
    w_addr1  = {bus.req_pa2[31:PAGE_BITS], {PAGE_BITS{1'b0}}};
    w_be0    = f_be_mask(w_bytes0);
    w_be1    = f_be_mask(w_bytes1);
    // Second chunk carries the bytes that did not fit, re-aligned to lane 0.
    w_data1  = bus.req_data >> {w_bytes0, 3'b000};
  end

  // Frame-offset bits of PA1/PA2 and the linear page number are not needed.
  logic w_unused;
  assign w_unused = ^{bus.req_pa1[PAGE_BITS-1:0], bus.req_pa2[PAGE_BITS-1:0],
                      bus.req_addr[31:PAGE_BITS], w_room[PAGE_BITS:4]};

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t      state_q;
  logic        req_stall_q;
  logic        mem_en_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  mem_be_q;
  logic [63:0] mem_data_q;
  logic        last_q;     // chunk currently presented is the final one
  logic [31:0] addr1_q;    // second chunk, prepared at acceptance time
  logic [7:0]  be1_q;
  logic [63:0] data1_q;

  // Same-cycle presentation of an unsplit request straight from WB.
  logic w_byp;
`ifdef WB_SEQ_BYPASS_EN
  assign w_byp = (state_q == S_IDLE) & bus.req_v & ~w_split & ~CLR;
`else
  assign w_byp = 1'b0;
`endif

  // Sequencer FSM: accepts a request, walks its chunks, returns to IDLE.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= S_IDLE;
      req_stall_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 8'h0;
      mem_data_q  <= 64'h0;
      last_q      <= 1'b0;
      addr1_q     <= 32'h0;
      be1_q       <= 8'h0;
      data1_q     <= 64'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A bypassed store that MEM takes immediately never leaves IDLE.
          if (bus.req_v && !(w_byp && bus.mem_rdy)) begin
            state_q     <= S_SEND0;
            req_stall_q <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_addr_q  <= w_addr0;
            mem_be_q    <= w_be0;
            mem_data_q  <= bus.req_data;
            last_q      <= ~w_split;
            addr1_q     <= w_addr1;
            be1_q       <= w_be1;
            data1_q     <= w_data1;
          end
        end

        S_SEND0: begin
          if (bus.mem_rdy) begin
            if (!last_q) begin
              state_q    <= S_SEND1;
              mem_addr_q <= addr1_q;
              mem_be_q   <= be1_q;
              mem_data_q <= data1_q;
              last_q     <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              req_stall_q <= 1'b0;
              mem_en_q    <= 1'b0;
              mem_addr_q  <= 32'h0;
              mem_be_q    <= 8'h0;
              mem_data_q  <= 64'h0;
              last_q      <= 1'b0;
            end
          end
        end

        S_SEND1: begin
          if (bus.mem_rdy) begin
            state_q     <= S_IDLE;
            req_stall_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 8'h0;
            mem_data_q  <= 64'h0;
            last_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          req_stall_q <= 1'b0;
          mem_en_q    <= 1'b0;
          last_q      <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive: registered chunk unless the bypass path is active.
  // --------------------------------------------------------------------------
  logic w_mem_en;
  assign w_mem_en      = mem_en_q | w_byp;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_addr  = w_byp ? w_addr0      : mem_addr_q;
  assign bus.mem_be    = w_byp ? w_be0        : mem_be_q;
  assign bus.mem_data  = w_byp ? bus.req_data : mem_data_q;
  assign bus.req_stall = req_stall_q;
  // Completion is seen in the cycle MEM takes the final chunk.
  assign bus.done      = w_mem_en & bus.mem_rdy & (w_byp | last_q);

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_wt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_mem_wt_sequencer
// Description : Directed self-checking bench for wb_mem_wt_sequencer with a
//               chunk scoreboard built by a byte-by-byte page model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_mem_wt_sequencer;

  localparam int PB = 12;
`ifdef WB_SEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  wb_mem_wt_sequencer_if bus ();

  wb_mem_wt_sequencer #(.PAGE_BITS(PB)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Page model: walk the store byte by byte and assign each byte to the page
  // it falls in, then queue the resulting chunks.
  task automatic push_store(input logic [31:0] addr, input logic [1:0] size,
                            input logic [63:0] data, input logic [31:0] pa1,
                            input logic [31:0] pa2, output bit split);
    int   nb, n0, n1, off;
    exp_t e;
    logic [63:0] d1;
    nb  = 1 << size;
    off = int'(addr[PB-1:0]);
    n0  = 0;
    n1  = 0;
    for (int i = 0; i < nb; i++) begin
      if (off + i < (1 << PB)) n0++;
      else n1++;
    end
    split  = (n1 > 0);
    e.addr = {pa1[31:PB], addr[PB-1:0]};
    e.be   = '0;
    for (int i = 0; i < n0; i++) e.be[i] = 1'b1;
    e.data = data;
    e.last = !split;
    sb.push_back(e);
    if (split) begin
      d1 = '0;
      for (int i = 0; i < 8; i++)
        if (i + n0 < 8) d1[8*i +: 8] = data[8*(i+n0) +: 8];
      e.addr = {pa2[31:PB], {PB{1'b0}}};
      e.be   = '0;
      for (int i = 0; i < n1; i++) e.be[i] = 1'b1;
      e.data = d1;
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Issue one store, hold MEM off for 'stall' cycles of presented chunk 0,
  // optionally toggle req_v while busy, and check every presented chunk.
  task automatic run_store(input string name, input logic [31:0] addr,
                           input logic [1:0] size, input logic [63:0] data,
                           input logic [31:0] pa1, input logic [31:0] pa2,
                           input int stall, input bit toggle);
    bit split;
    bit first;
    int waited;
    int cyc;
    push_store(addr, size, data, pa1, pa2, split);
    first  = 1'b1;
    waited = 0;
    cyc    = 0;
    @(posedge CLK); #1;
    bus.req_v    = 1'b1;
    bus.req_addr = addr;
    bus.req_size = size;
    bus.req_data = data;
    bus.req_pa1  = pa1;
    bus.req_pa2  = pa2;
    bus.mem_rdy  = 1'b0;
    while (sb.size() > 0 && cyc < 40) begin
      if (!first) begin
        bus.req_v    = toggle ? ~bus.req_v : 1'b0;
        bus.req_addr = ~addr;
        bus.req_data = ~data;
        bus.req_pa1  = ~pa1;
        bus.req_pa2  = ~pa2;
      end
      #1;
      if (first) chk({name, "_first_mem_en"}, 64'(bus.mem_en), 64'(BYP && !split));
      if (bus.mem_en) begin
        bus.mem_rdy = (waited >= stall);
        #1;
        chk({name, "_addr"},  64'(bus.mem_addr),  64'(sb[0].addr));
        chk({name, "_be"},    64'(bus.mem_be),    64'(sb[0].be));
        chk({name, "_data"},  bus.mem_data,       sb[0].data);
        chk({name, "_stall"}, 64'(bus.req_stall), 64'(!first));
        chk({name, "_done"},  64'(bus.done),      64'(bus.mem_rdy && sb[0].last));
        if (bus.mem_rdy) void'(sb.pop_front());
        else waited++;
      end else begin
        bus.mem_rdy = 1'b1;
        #1;
        chk({name, "_idle_done"}, 64'(bus.done), 64'd0);
        if (!first) chk({name, "_mem_en_dropped"}, 64'(bus.mem_en), 64'd1);
      end
      first = 1'b0;
      cyc++;
      if (sb.size() > 0) begin
        @(posedge CLK); #1;
      end
    end
    if (sb.size() > 0) begin
      chk({name, "_timeout_pending"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge CLK); #1;
    bus.req_v   = 1'b0;
    bus.mem_rdy = 1'b0;
    #1;
    chk({name, "_after_stall"},  64'(bus.req_stall), 64'd0);
    chk({name, "_after_mem_en"}, 64'(bus.mem_en),    64'd0);
    chk({name, "_after_done"},   64'(bus.done),      64'd0);
  endtask

  initial begin
    bus.req_v    = 1'b0;
    bus.req_addr = '0;
    bus.req_size = '0;
    bus.req_data = '0;
    bus.req_pa1  = '0;
    bus.req_pa2  = '0;
    bus.mem_rdy  = 1'b0;
    CLR          = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_stall", 64'(bus.req_stall), 64'd0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_be", 64'(bus.mem_be), 64'd0);
    chk("rst_data", bus.mem_data, 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    CLR = 1'b0;

    // Plain 4-byte store
    run_store("t1_plain", 32'h0000_1004, 2'b10, 64'hAABB_CCDD, 32'h0003_5000, 32'h0, 0, 1'b0);
    // 4-byte store crossing a page: 2 + 2 bytes
    run_store("t2_cross", 32'h0000_0FFE, 2'b10, 64'h1122_3344, 32'h0001_0000, 32'h0002_0000, 0, 1'b0);
    // 8-byte store at 0xFF9: 7 + 1 bytes
    run_store("t3_cross8", 32'h0000_0FF9, 2'b11, 64'h0102_0304_0506_0708, 32'h0001_0000, 32'h0002_0000, 0, 1'b0);
    // Ends exactly on the last byte of the page: no split
    run_store("t4_edge4", 32'h0000_0FFC, 2'b10, 64'hDEAD_BEEF, 32'h0004_4000, 32'h0005_5000, 0, 1'b0);
    run_store("t4_edge8", 32'h0000_0FF8, 2'b11, 64'h8877_6655_4433_2211, 32'h0004_4000, 32'h0005_5000, 0, 1'b0);
    run_store("t4_edge1", 32'h0000_0FFF, 2'b00, 64'h0000_00A5, 32'h0006_6000, 32'h0007_7000, 0, 1'b0);
    // 2-byte store on the last byte: 1 + 1, offset must not carry into frame
    run_store("t4_wrap2", 32'h0000_1FFF, 2'b01, 64'h0000_BEEF, 32'h0001_F000, 32'h0009_9000, 0, 1'b0);
    // MEM back-pressure with req_v toggling
    run_store("t5_bp", 32'h0000_1004, 2'b10, 64'hAABB_CCDD, 32'h0003_5000, 32'h0, 5, 1'b1);
    run_store("t5_bp_split", 32'h0000_0FFA, 2'b11, 64'hF0E1_D2C3_B4A5_9687, 32'h00AB_C000, 32'h00DE_F000, 3, 1'b1);

    // Reset asserted while the second chunk waits for MEM
    @(posedge CLK); #1;
    bus.req_v    = 1'b1;
    bus.req_addr = 32'h0000_0FFE;
    bus.req_size = 2'b10;
    bus.req_data = 64'h1122_3344;
    bus.req_pa1  = 32'h0001_0000;
    bus.req_pa2  = 32'h0002_0000;
    bus.mem_rdy  = 1'b0;
    @(posedge CLK); #1;
    bus.req_v   = 1'b0;
    bus.mem_rdy = 1'b1;
    #1;
    chk("t6_chunk0_addr", 64'(bus.mem_addr), 64'h0001_0FFE);
    chk("t6_chunk0_done", 64'(bus.done), 64'd0);
    @(posedge CLK); #1;
    bus.mem_rdy = 1'b0;
    #1;
    chk("t6_chunk1_addr", 64'(bus.mem_addr), 64'h0002_0000);
    chk("t6_chunk1_en", 64'(bus.mem_en), 64'd1);
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    bus.mem_rdy = 1'b1;
    #1;
    chk("t6_clr_mem_en", 64'(bus.mem_en), 64'd0);
    chk("t6_clr_stall", 64'(bus.req_stall), 64'd0);
    chk("t6_clr_done", 64'(bus.done), 64'd0);
    chk("t6_clr_addr", 64'(bus.mem_addr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("t6_no_more_chunks", 64'(bus.mem_en), 64'd0);
    end
    bus.mem_rdy = 1'b0;
    run_store("t6_after_clr", 32'h0000_1004, 2'b10, 64'hAABB_CCDD, 32'h0003_5000, 32'h0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_mem_wt_sequencer.md
Name: wb_mem_wt_sequencer

Overview:
- Sequences write-back stage memory writes into the MEM write port.
- Splits any store that crosses a page boundary into two physical-page chunks: first chunk uses the PA1 frame, second uses the PA2 frame.
- Handshakes each chunk with MEM and stalls write-back until the whole store is accepted.
- Sits between the WB control logic and MEM, replacing the direct one-shot write enable.

Parameters:
- PAGE_BITS, 12, log2 of page size in bytes; the page offset is addr[PAGE_BITS-1:0].

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset; synchronous, active-high.
- req_v  in  1  write request valid from WB.
- req_addr  in  32  linear address of the first byte.
- req_size  in  2  size code: 00=1B, 01=2B, 10=4B, 11=8B.
- req_data  in  64  store data, little-endian, right-aligned (byte 0 in [7:0]).
- req_pa1  in  32  physical frame of the first page; bits [31:PAGE_BITS] used.
- req_pa2  in  32  physical frame of the second page; bits [31:PAGE_BITS] used.
- req_stall  out  1  request cannot be accepted this cycle; WB holds its request.
- mem_en  out  1  chunk write valid to MEM.
- mem_addr  out  32  physical address of the chunk's first byte.
- mem_be  out  8  byte enables, contiguous from bit 0.
- mem_data  out  64  chunk data, right-aligned.
- mem_rdy  in  1  MEM accepts the presented chunk this cycle.
- done  out  1  one-cycle pulse when the final chunk is accepted.

Behaviour:
- Reset: state=IDLE; all request registers cleared. req_stall=0, mem_en=0, mem_addr=0, mem_be=0, mem_data=0, done=0.
- CLR has priority over every event. Asserting it mid-operation drops the pending store; no further chunks issue.
- States: IDLE, SEND0, SEND1.
- IDLE
  - req_stall=0, mem_en=0.
  - If req_v=1: latch addr/size/data/pa1/pa2; go to SEND0. First chunk is presented the following cycle (1-cycle latency).
- Chunk computation (from latched values):
  - bytes = 1<<size; off = addr[PAGE_BITS-1:0].
  - split = (off + bytes) > 2^PAGE_BITS, evaluated at PAGE_BITS+1 bits, no overflow.
  - bytes0 = split ? (2^PAGE_BITS - off) : bytes; range 1..7 when split.
  - bytes1 = bytes - bytes0.
- SEND0
  - mem_en=1; mem_addr={pa1[31:PAGE_BITS], off}.
  - mem_be = (1<<bytes0)-1; mem_data = data.
  - On mem_rdy: if split, go to SEND1; else done=1 and go to IDLE.
- SEND1
  - mem_en=1; mem_addr={pa2[31:PAGE_BITS], PAGE_BITS'b0}.
  - mem_be = (1<<bytes1)-1; mem_data = data >> (8*bytes0).
  - On mem_rdy: done=1, go to IDLE.
- req_stall=1 in SEND0 and SEND1. req_v there is ignored; no overlap and no back-to-back acceptance in the done cycle.
- While mem_en=1 and mem_rdy=0, mem_addr, mem_be and mem_data hold stable. mem_rdy wait time is unbounded.
- mem_rdy while mem_en=0 is ignored.
- A store ending exactly on the page's last byte (off+bytes == 2^PAGE_BITS) is not split.
- An offset wrap never carries into the frame bits.
- done is registered-free combinational: mem_en & mem_rdy & last-chunk.

Optional Feature:
- Macro: WB_SEQ_BYPASS_EN.
- Defined:
  - In IDLE with req_v=1 and the request not split, mem_en/addr/be/data are driven combinationally from req_* in the same cycle.
  - If mem_rdy=1 in that cycle: done=1, state stays IDLE, req_stall=0 (zero-latency store).
  - If mem_rdy=0: the request is latched and the FSM enters SEND0 as normal.
  - Split requests always take the registered path.
- Undefined: every store takes at least one cycle from acceptance to mem_en.

Test Plan:
1. Plain 4-byte store, no split.
   - Stimulus: req_v, addr=0x00001004, size=10, pa1=0x00035000, data=0xAABBCCDD, mem_rdy=1.
   - Response: next cycle mem_en=1, mem_addr=0x00035004, mem_be=0x0F, mem_data=0xAABBCCDD, done=1; the cycle after, req_stall=0, mem_en=0.
2. 4-byte store crossing a page.
   - Stimulus: addr=0x00000FFE, size=10, pa1=0x00010000, pa2=0x00020000, data=0x11223344, mem_rdy=1.
   - Response: chunk0 addr=0x00010FFE, be=0x03, data low=0x3344, done=0; chunk1 addr=0x00020000, be=0x03, data low=0x1122, done=1.
3. 8-byte store at offset 0xFF9.
   - Stimulus: data=0x0102030405060708.
   - Response: chunk0 be=0x7F; chunk1 be=0x01, mem_data=0x01.
4. Store at offset 0xFFC, size=10.
   - Response: single chunk, be=0x0F, no SEND1.
5. MEM back-pressure.
   - Stimulus: mem_rdy=0 for 5 cycles during SEND0, while req_v toggles.
   - Response: mem outputs constant, req_stall=1, done=0, toggling req_v ignored; completes on the first cycle mem_rdy=1.
6. Reset and bypass.
   - CLR asserted during SEND1: next cycle mem_en=0, req_stall=0, done=0; a new request then proceeds normally.
   - With WB_SEQ_BYPASS_EN, case 1 gives mem_en and done in the request cycle.
